// File: rtl/nios_system_nios2_gen2_0_cpu_mul_seq_pkg.sv
// Shared definitions for the multi-cycle multiply sequencer:
// op encodings, FSM state type and the multiplier cell half-word width.
package nios_system_nios2_gen2_0_cpu_mul_seq_pkg;

    // Half-word width handled by the 16x16 partial-product cell.
    localparam int HALF_W = 16;

    // Multiply op encodings.
    localparam logic [1:0] OP_MUL    = 2'd0;  // low word
    localparam logic [1:0] OP_MULXUU = 2'd1;  // high word, unsigned x unsigned
    localparam logic [1:0] OP_MULXSU = 2'd2;  // high word, signed x unsigned
    localparam logic [1:0] OP_MULXSS = 2'd3;  // high word, signed x signed

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISS_LO = 3'd1,
        ST_CAP_LO = 3'd2,
        ST_CAP_HI = 3'd3,
        ST_FIX    = 3'd4,
        ST_DONE   = 3'd5
    } mul_state_e;

endpackage

// File: rtl/nios_system_nios2_gen2_0_cpu_mul_seq_if.sv
// Bundle between the multiply sequencer, its requester and the multiplier cell.
// The slave modport is the sequencer; the master modport is the surrounding
// CPU logic plus the partial-product cell.
interface nios_system_nios2_gen2_0_cpu_mul_seq_if;

    // Request side
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    // Multiplier cell side
    logic [31:0] E_src1;
    logic [31:0] E_src2;
    logic        M_en;
    logic [31:0] M_mul_cell_p1;
    logic [31:0] M_mul_cell_p2;
    logic [31:0] M_mul_cell_p3;

    modport slave (
        input  start, op, a, b,
        input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        output busy, done, result,
        output E_src1, E_src2, M_en
    );

    modport master (
        output start, op, a, b,
        output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
        input  busy, done, result,
        input  E_src1, E_src2, M_en
    );

endinterface

// File: rtl/nios_system_nios2_gen2_0_cpu_mul_seq.sv
// Multi-cycle multiply sequencer driving a registered 16x16 partial-product
// cell. First pass builds the 32-bit low word; with NIOS_CPU_MULX_EN defined a
// second pass on the upper halves builds the high word for mulxuu/mulxsu/mulxss.
// With NIOS_CPU_MULX_EN undefined every op runs as a plain low-word multiply.
module nios_system_nios2_gen2_0_cpu_mul_seq
    import nios_system_nios2_gen2_0_cpu_mul_seq_pkg::*;
(
    input  logic                                  clk,
    input  logic                                  reset_n,
    nios_system_nios2_gen2_0_cpu_mul_seq_if.slave bus
);

    mul_state_e  state_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] result_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic        m_en_q;
    logic        busy_q;
    logic        done_q;

    // Low word: p1 + (mid << 16), mid = p2 + p3. Bits shifted past 32 drop out.
    logic [31:0] lo_word;
    assign lo_word = bus.M_mul_cell_p1 + ((bus.M_mul_cell_p2 + bus.M_mul_cell_p3) << HALF_W);

`ifdef NIOS_CPU_MULX_EN
    logic [1:0]  op_q;
    logic [16:0] mid_hi_q;   // carry-extended upper part of the cross-term sum
    logic        c_q;        // carry out of the low-word addition
    logic [31:0] hi_u_q;     // unsigned high word before sign correction

    logic [32:0] mid_sum;
    logic [32:0] lo_sum;
    logic [31:0] hi_u_sum;
    logic [31:0] corr_a;
    logic [31:0] corr_b;
    logic [31:0] hi_word;

    assign mid_sum  = {1'b0, bus.M_mul_cell_p2} + {1'b0, bus.M_mul_cell_p3};
    assign lo_sum   = {1'b0, bus.M_mul_cell_p1} + {1'b0, mid_sum[15:0], 16'h0};
    assign hi_u_sum = bus.M_mul_cell_p1 + {15'h0, mid_hi_q} + {31'h0, c_q};

    // Two's-complement correction: a negative signed operand contributes
    // -(other operand) << 32 relative to the unsigned product.
    assign corr_a  = (a_q[31] && (op_q == OP_MULXSU || op_q == OP_MULXSS)) ? b_q : 32'h0;
    assign corr_b  = (b_q[31] && (op_q == OP_MULXSS)) ? a_q : 32'h0;
    assign hi_word = hi_u_q - corr_a - corr_b;
`endif

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            result_q <= 32'h0;
            src1_q   <= 32'h0;
            src2_q   <= 32'h0;
            m_en_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef NIOS_CPU_MULX_EN
            op_q     <= OP_MUL;
            mid_hi_q <= 17'h0;
            c_q      <= 1'b0;
            hi_u_q   <= 32'h0;
`endif
        end else begin
            done_q <= 1'b0;
            m_en_q <= 1'b0;
            src1_q <= 32'h0;
            src2_q <= 32'h0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
`ifdef NIOS_CPU_MULX_EN
                        op_q    <= bus.op;
`endif
                        src1_q  <= bus.a;
                        src2_q  <= bus.b;
                        m_en_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_ISS_LO;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISS_LO: begin
`ifdef NIOS_CPU_MULX_EN
                    // Second pass (upper halves) is issued while CAP_LO captures.
                    if (op_q != OP_MUL) begin
                        src1_q <= {16'h0, a_q[31:16]};
                        src2_q <= {16'h0, b_q[31:16]};
                        m_en_q <= 1'b1;
                    end
`endif
                    state_q <= ST_CAP_LO;
                end
                ST_CAP_LO: begin
`ifdef NIOS_CPU_MULX_EN
                    if (op_q == OP_MUL) begin
                        result_q <= lo_word;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        mid_hi_q <= mid_sum[32:16];
                        c_q      <= lo_sum[32];
                        state_q  <= ST_CAP_HI;
                    end
`else
                    result_q <= lo_word;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
`endif
                end
`ifdef NIOS_CPU_MULX_EN
                ST_CAP_HI: begin
                    hi_u_q  <= hi_u_sum;
                    state_q <= ST_FIX;
                end
                ST_FIX: begin
                    result_q <= hi_word;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
                end
`endif
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.E_src1 = src1_q;
    assign bus.E_src2 = src2_q;
    assign bus.M_en   = m_en_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_nios_system_nios2_gen2_0_cpu_mul_seq.sv
// Directed testbench for the multiply sequencer. Includes a behavioural model
// of the registered 16x16 partial-product cell. Expected high-word results and
// latencies follow NIOS_CPU_MULX_EN.
module tb_nios_system_nios2_gen2_0_cpu_mul_seq;

`ifdef NIOS_CPU_MULX_EN
    localparam int          XLAT  = 5;
    localparam logic [31:0] XMASK = 32'h6;
`else
    localparam int          XLAT  = 3;
    localparam logic [31:0] XMASK = 32'h2;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    nios_system_nios2_gen2_0_cpu_mul_seq_if bus();

    nios_system_nios2_gen2_0_cpu_mul_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    // Partial-product cell: registered products, held while M_en is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.M_mul_cell_p1 <= 32'h0;
            bus.M_mul_cell_p2 <= 32'h0;
            bus.M_mul_cell_p3 <= 32'h0;
        end else if (bus.M_en) begin
            bus.M_mul_cell_p1 <= 32'(bus.E_src1[15:0])  * 32'(bus.E_src2[15:0]);
            bus.M_mul_cell_p2 <= 32'(bus.E_src1[15:0])  * 32'(bus.E_src2[31:16]);
            bus.M_mul_cell_p3 <= 32'(bus.E_src1[31:16]) * 32'(bus.E_src2[15:0]);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One request: accept edge T, then sample each following cycle on negedge.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input logic [31:0] exp_mask);
        int k;
        logic [31:0] mask;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.a = 32'hDEAD_BEEF; bus.b = 32'h1357_9BDF;
        check_val({tag, "_busy"}, {31'h0, bus.busy}, 32'h1);
        check_val({tag, "_src1"}, bus.E_src1, a);
        check_val({tag, "_src2"}, bus.E_src2, b);
        k = 1;
        mask = 32'h0;
        forever begin
            mask[k] = bus.M_en;
            if (bus.done || k >= 20) break;
            @(negedge clk);
            k++;
        end
        check_val({tag, "_lat"}, 32'(k), 32'(exp_lat));
        check_val({tag, "_res"}, bus.result, exp_res);
        check_val({tag, "_men"}, mask, exp_mask);
        @(negedge clk);
        check_val({tag, "_pulse"}, {31'h0, bus.done}, 32'h0);
        check_val({tag, "_hold"}, bus.result, exp_res);
        $display("txn %s op=%0d a=%h b=%h -> result=%h latency=%0d", tag, op, a, b, bus.result, k);
    endtask

    initial begin
        int seen_done;
        bus.start = 1'b0; bus.op = 2'd0; bus.a = 32'h0; bus.b = 32'h0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_val("rst_busy",   {31'h0, bus.busy}, 32'h0);
        check_val("rst_done",   {31'h0, bus.done}, 32'h0);
        check_val("rst_men",    {31'h0, bus.M_en}, 32'h0);
        check_val("rst_src1",   bus.E_src1, 32'h0);
        check_val("rst_result", bus.result, 32'h0);
        reset_n = 1'b1;

        run_op("mul_small", 2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3, 32'h2);
        run_op("mul_neg",   2'd0, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, 3, 32'h2);
`ifdef NIOS_CPU_MULX_EN
        run_op("mulxuu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, XLAT, XMASK);
        run_op("mulxss_ff", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, XLAT, XMASK);
        run_op("mulxsu_ff", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, XLAT, XMASK);
        run_op("mulxuu_2p32", 2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, XLAT, XMASK);
        run_op("mulxsu_min", 2'd2, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, XLAT, XMASK);
`else
        run_op("mulxuu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, XLAT, XMASK);
        run_op("mulxss_ff", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, XLAT, XMASK);
        run_op("mulxsu_ff", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, XLAT, XMASK);
        run_op("mulxuu_2p32", 2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, XLAT, XMASK);
        run_op("mulxsu_min", 2'd2, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, XLAT, XMASK);
`endif

        // start while busy is ignored; start in DONE issues the next op at once
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'h0001_0003; bus.b = 32'h0002_0005;
        @(negedge clk);
        bus.a = 32'h0000_0005; bus.b = 32'h0000_0007;     // ignored: busy
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check_val("b2b_done1", {31'h0, bus.done}, 32'h1);
        check_val("b2b_res1",  bus.result, 32'h000B_000F);
        bus.start = 1'b1; bus.a = 32'h0000_1234; bus.b = 32'h0000_0010;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("b2b_busy2", {31'h0, bus.busy}, 32'h1);
        check_val("b2b_men2",  {31'h0, bus.M_en}, 32'h1);
        check_val("b2b_src2",  bus.E_src1, 32'h0000_1234);
        @(negedge clk);
        @(negedge clk);
        check_val("b2b_done2", {31'h0, bus.done}, 32'h1);
        check_val("b2b_res2",  bus.result, 32'h0001_2340);
        $display("txn b2b second result=%h", bus.result);

        // reset in the middle of a MULX request
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd1; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
`ifdef NIOS_CPU_MULX_EN
        @(negedge clk);
`endif
        reset_n = 1'b0;
        #1;
        check_val("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
        check_val("mid_rst_done", {31'h0, bus.done}, 32'h0);
        check_val("mid_rst_men",  {31'h0, bus.M_en}, 32'h0);
        check_val("mid_rst_src2", bus.E_src2, 32'h0);
        check_val("mid_rst_res",  bus.result, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done) seen_done++;
        end
        check_val("mid_rst_nodone", 32'(seen_done), 32'h0);
        $display("txn reset mid-op, done pulses after=%0d", seen_done);
        run_op("post_rst", 2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 3, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nios_system_nios2_gen2_0_cpu_mul_seq.md
# nios_system_nios2_gen2_0_cpu_mul_seq

Multi-cycle multiply sequencer that drives the CPU's 16x16 partial-product multiplier cell. It latches a multiply request and issues operands plus the stage enable to the cell. It collects the three registered partial products (lo*lo, src1_lo*src2_hi, src1_hi*src2_lo) and assembles the 32-bit `mul` result. When `mulx` support is compiled in, it runs a second pass through the cell to build the high word for `mulxuu`, `mulxsu` and `mulxss`.

## Interface
- No parameters. Widths are fixed: 32-bit operands, 16-bit cell halves.
- `clk` in 1: CPU clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe. Accepted only when `busy`=0.
- `op` in 2: 0=MUL (low word), 1=MULXUU, 2=MULXSU (a signed, b unsigned), 3=MULXSS.
- `a`, `b` in 32: operands. Sampled on the accepting edge.
- `E_src1`, `E_src2` out 32: operands to the cell.
- `M_en` out 1: cell register enable.
- `M_mul_cell_p1`, `M_mul_cell_p2`, `M_mul_cell_p3` in 32: partial products from the cell. They are valid the cycle after `M_en`=1.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle pulse. `result` is valid in that cycle.
- `result` out 32: product word. Held until the next `done`.

## Operation
- FSM states: IDLE, ISS_LO, CAP_LO, CAP_HI, FIX, DONE.
- IDLE/DONE + `start`: latch `a`, `b`, `op` into `a_q`, `b_q`, `op_q`, then go to ISS_LO.
- ISS_LO: `E_src1`=`a_q`, `E_src2`=`b_q`, `M_en`=1. Next state is CAP_LO.
- CAP_LO: compute from the cell outputs:
  - mid = p2 + p3 (33 bits).
  - lo = p1 + {mid[15:0],16'h0} (33 bits). c = lo[32].
  - Register lo[31:0], mid[32:16] and c.
- CAP_LO transitions:
  - MUL: `result`←lo[31:0], go to DONE.
  - Otherwise: in the same cycle drive `E_src1`={16'h0,a_q[31:16]}, `E_src2`={16'h0,b_q[31:16]}, `M_en`=1, and go to CAP_HI.
- CAP_HI: hi_u = p1 + mid[32:16] + c, computed mod 2^32 and registered. Next state is FIX.
- FIX: hi = hi_u − (a_q[31] && op_q∈{2,3} ? b_q : 0) − (b_q[31] && op_q==3 ? a_q : 0), mod 2^32. `result`←hi. Next state is DONE.
- DONE: `done`=1 for one cycle. Go to IDLE, or straight to ISS_LO if `start` is accepted in this cycle.
- `M_en`=0 in all states other than ISS_LO and the MULX CAP_LO. The cell holds its products while `M_en`=0.
- `E_src1`/`E_src2` drive 0 whenever `M_en`=0.
- `busy`=1 in ISS_LO, CAP_LO, CAP_HI and FIX. `busy`=0 in IDLE and DONE.
- `start` while `busy`=1 is ignored: no queueing and no error.
- Operands are not re-sampled mid-operation. Changes on `a`/`b` after acceptance have no effect.

## Timing
- Accepting edge is T. ISS_LO is T+1.
- MUL: CAP_LO at T+2, `done` at T+3.
- MULX: CAP_HI at T+3, FIX at T+4, `done` at T+5.
- Back-to-back: a `start` asserted during DONE gives a new ISS_LO the next cycle. Minimum spacing is 3 cycles (MUL) or 5 cycles (MULX).
- Reset values (asynchronous): state=IDLE; `busy`, `done`, `M_en`=0; `E_src1`, `E_src2`, `result`=0; all internal registers 0.
- Reset mid-operation aborts the operation. No `done` pulse follows. The cell is reset by the same `reset_n`.

## Configuration
- `NIOS_CPU_MULX_EN` defined: all four `op` codes are supported as above.
- `NIOS_CPU_MULX_EN` undefined:
  - CAP_HI, FIX and the hi-word datapath are removed.
  - Every `op` is executed as MUL and returns the low word at T+3.
  - `op` is ignored.

## Structure
- Shared package holds:
  - the `op` encoding constants (MUL, MULXUU, MULXSU, MULXSS);
  - the FSM state enum;
  - the half-word width constant (16).
- No sub-module. The parent instantiates this block and the multiplier cell side by side and wires them together.

## Test plan
- MUL, a=0x0001_0003, b=0x0002_0005 → `done` at T+3, `result`=0x000B_000F; `M_en` high only at T+1.
- MULXUU, a=b=0xFFFF_FFFF → `done` at T+5, `result`=0xFFFF_FFFE.
- MULXSS, a=b=0xFFFF_FFFF → `result`=0x0000_0000. MULXSU with the same operands → `result`=0xFFFF_FFFF.
- `start` pulsed during `busy`, then a second `start` in the DONE cycle → the first is ignored, the second is issued at the following cycle, and its result is correct.
- `reset_n` low at T+3 of a MULX → outputs go to 0 immediately, no `done` pulse, and the next request completes normally.
- Build without `NIOS_CPU_MULX_EN`, op=MULXUU, a=b=0xFFFF_FFFF → `done` at T+3, `result`=0x0000_0001.
